// File: rtl/bip_debug_ctrl.sv
// Byte-command debug sequencer between the UART and the BIP core: loads program memory,
// runs or single-steps the core, then reports PC, ACC and executed-cycle count over TX.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// S_IDLE       | waiting for a command byte ('L', 'R', 'S'); others ignored
// S_LD_HI      | waiting for instruction high byte
// S_LD_LO      | waiting for instruction low byte
// S_LD_WR      | program-memory write strobe high; decide next word or end
// S_RUN        | core enabled until halt flag seen
// S_STEP       | core enabled for a single cycle unless already halted
// S_SND_LATCH  | snapshot PC/ACC/count into the report buffer
// S_SND_BYTE   | launch the current report byte
// S_SND_WAIT   | waiting for the UART to finish the current byte
module bip_debug_ctrl #(
    parameter int         NBITS_0  = 11,
    parameter int         NBITS_D  = 16,
    parameter int         OPCODE   = 5,
    parameter logic [7:0] CMD_LOAD = 8'h4C,
    parameter logic [7:0] CMD_RUN  = 8'h52,
    parameter logic [7:0] CMD_STEP = 8'h53
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_RxData,
    input  logic               i_RxValid,
    output logic [7:0]         o_TxData,
    output logic               o_TxStart,
    input  logic               i_TxDone,
    output logic               o_ProgWrEn,
    output logic [NBITS_0-1:0] o_ProgAddr,
    output logic [NBITS_D-1:0] o_ProgData,
    output logic               o_CpuEnable,
    output logic               o_CpuReset,
    input  logic               i_Halt,
    input  logic [NBITS_0-1:0] i_PC,
    input  logic [NBITS_D-1:0] i_Acc
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_HI,
        S_LD_LO,
        S_LD_WR,
        S_RUN,
        S_STEP,
        S_SND_LATCH,
        S_SND_BYTE,
        S_SND_WAIT
    } state_t;

    localparam logic [NBITS_0-1:0] ADDR_MAX = '1;
    localparam logic [2:0]         LAST_IDX = 3'd5;

    state_t             state_q, state_d;
    logic [NBITS_0-1:0] addr_q, addr_d;
    logic [NBITS_D-1:0] data_q, data_d;
    logic               wr_q, wr_d;
    logic               en_q, en_d;
    logic               rst_q, rst_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [47:0]        snap_q, snap_d;
    logic [2:0]         idx_q, idx_d;
    logic [15:0]        pc_ext;
    logic [7:0]         snap_byte;
    logic               op_is_halt;

    assign pc_ext     = {{(16-NBITS_0){1'b0}}, i_PC};
    assign op_is_halt = (data_q[NBITS_D-1 -: OPCODE] == '0);

    always_comb begin
        snap_byte = 8'h00;
        case (idx_q)
            3'd0:    snap_byte = snap_q[47:40];
            3'd1:    snap_byte = snap_q[39:32];
            3'd2:    snap_byte = snap_q[31:24];
            3'd3:    snap_byte = snap_q[23:16];
            3'd4:    snap_byte = snap_q[15:8];
            3'd5:    snap_byte = snap_q[7:0];
            default: snap_byte = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            en_q       <= 1'b0;
            rst_q      <= 1'b1;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            cnt_q      <= 16'h0000;
            snap_q     <= 48'h0;
            idx_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            en_q       <= en_d;
            rst_q      <= rst_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            idx_q      <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_d       = 1'b0;
        en_d       = 1'b0;
        rst_d      = rst_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        snap_d     = snap_q;
        idx_d      = idx_q;
        // Count every cycle the core was actually enabled, saturating.
        cnt_d      = (en_q && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;

        case (state_q)
            S_IDLE: begin
                if (i_RxValid) begin
                    if (i_RxData == CMD_LOAD) begin
                        state_d = S_LD_HI;
                        rst_d   = 1'b1;
                        addr_d  = '0;
                        cnt_d   = 16'h0000;
                    end else if (i_RxData == CMD_RUN) begin
                        state_d = S_RUN;
                        rst_d   = 1'b0;
                    end else if (i_RxData == CMD_STEP) begin
                        state_d = S_STEP;
                        rst_d   = 1'b0;
                    end
                end
            end
            S_LD_HI: begin
                if (i_RxValid) begin
                    data_d[NBITS_D-1 -: 8] = i_RxData;
                    state_d                = S_LD_LO;
                end
            end
            S_LD_LO: begin
                if (i_RxValid) begin
                    data_d[7:0] = i_RxData;
                    wr_d        = 1'b1;
                    state_d     = S_LD_WR;
                end
            end
            S_LD_WR: begin
                if (addr_q != ADDR_MAX) begin
                    addr_d = addr_q + NBITS_0'(1);
                end
                if (op_is_halt || (addr_q == ADDR_MAX)) begin
                    state_d = S_IDLE;
                    rst_d   = 1'b0;
                end else begin
                    state_d = S_LD_HI;
                end
            end
            S_RUN: begin
                // Halt seen on entry or while enabled: stop without a further enable cycle.
                if (i_Halt) begin
                    state_d = S_SND_LATCH;
                end else begin
                    en_d = 1'b1;
                end
            end
            S_STEP: begin
                if (en_q || i_Halt) begin
                    state_d = S_SND_LATCH;
                end else begin
                    en_d = 1'b1;
                end
            end
            S_SND_LATCH: begin
                snap_d  = {pc_ext, 16'(i_Acc), cnt_q};
                idx_d   = 3'd0;
                state_d = S_SND_BYTE;
            end
            S_SND_BYTE: begin
                tx_data_d  = snap_byte;
                tx_start_d = 1'b1;
                state_d    = S_SND_WAIT;
            end
            S_SND_WAIT: begin
                if (i_TxDone) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_SND_BYTE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_TxData    = tx_data_q;
    assign o_TxStart   = tx_start_q;
    assign o_ProgWrEn  = wr_q;
    assign o_ProgAddr  = addr_q;
    assign o_ProgData  = data_q;
    assign o_CpuEnable = en_q;
    assign o_CpuReset  = rst_q;

endmodule
